rmii_rx_dibit_asm: RTL and testbench

RMII_RX_DIBIT_ASM -- requirements
Module: rmii_rx_dibit_asm

---
 rtl/rmii_rx_dibit_asm.sv | 229 ++++++++++++++++++++++
 tb/tb_rmii_rx_dibit_asm.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_rx_dibit_asm.sv
`default_nettype none
// ============================================================================
//  Module   : rmii_rx_dibit_asm
//  Purpose  : RMII receive dibit assembler. Samples RXD/CRS_DV on rmii_clk,
//             finds byte alignment on the preamble, packs dibits LSB-first
//             into bytes and hands bytes and frame status to the clk domain.
//  Ports    : clk/rst            - system clock, async active-high reset
//             rmii_clk           - 50 MHz RMII reference clock
//             fast_eth           - 1 = 100 Mb/s, 0 = 10 Mb/s (quasi-static)
//             rm_rx_data/crs_dv  - RMII RXD[1:0] and CRS_DV
//             data/rdy           - assembled byte and its one-clk strobe
//             busy/done          - frame-in-progress level, end-of-frame pulse
//             frame_len/err_align- whole-byte count and partial-byte flag
//  Revision : 1.0 - initial release
// ============================================================================
module rmii_rx_dibit_asm #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rmii_clk,
    input  logic        fast_eth,
    input  logic [1:0]  rm_rx_data,
    input  logic        rm_crs_dv,
    output logic [7:0]  data,
    output logic        rdy,
    output logic        busy,
    output logic        done,
    output logic [15:0] frame_len,
    output logic        err_align
);

    localparam int c_SYNC_DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_RECV  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Reset for the rmii_clk domain: asserts immediately, releases on
    // rmii_clk so no flop sees a deassertion near its clock edge.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_pipe;
    logic       w_rm_rst;

    always_ff @(posedge rmii_clk or posedge rst) begin
        if (rst) r_rst_pipe <= 2'b00;
        else     r_rst_pipe <= {r_rst_pipe[0], 1'b1};
    end
    assign w_rm_rst = ~r_rst_pipe[1];

    // ------------------------------------------------------------------
    // rmii_clk domain
    // ------------------------------------------------------------------
    state_t      r_state, w_state_nxt;
    logic        r_skip;        // ignore an aborted frame until CRS_DV idles
    logic        r_low_prev;    // previous sample point had CRS_DV=0
    logic [3:0]  r_div;
    logic [1:0]  r_dcnt;        // dibits already packed into r_shift
    logic [7:0]  r_shift;
    logic        r_pend;        // a single-low dibit awaiting confirmation
    logic [1:0]  r_pend_d;
    logic [15:0] r_cnt;
    logic [7:0]  r_hold;
    logic        r_byte_tgl, r_eof_tgl, r_active;
    logic [15:0] r_len_hold;
    logic        r_err_hold;

    logic        w_hunt, w_samp, w_eof, w_align;
    logic [7:0]  w_s1, w_s2, w_byte;
    logic [1:0]  w_c1;
    logic        w_done1, w_done2, w_byte_done;

    // While hunting for alignment every edge is examined, so that in 10 Mb/s
    // mode the divider can be restarted on the very edge carrying the 01.
    assign w_hunt  = (r_state == S_IDLE) || (r_state == S_ALIGN);
    assign w_samp  = fast_eth || w_hunt || (r_div == 4'd0);
    assign w_eof   = w_samp && !rm_crs_dv && r_low_prev;
    assign w_align = w_samp && (r_state == S_ALIGN) && !w_eof
                     && rm_crs_dv && (rm_rx_data == 2'b01);

    // A low sample is only known to be data once the next sample is high,
    // so its dibit is parked in r_pend and packed ahead of the current one.
    // At most one of the two steps can complete a byte.
    assign w_s1        = r_pend ? {r_pend_d, r_shift[7:2]} : r_shift;
    assign w_c1        = r_pend ? (r_dcnt + 2'd1) : r_dcnt;
    assign w_done1     = r_pend && (r_dcnt == 2'd3);
    assign w_s2        = {rm_rx_data, w_s1[7:2]};
    assign w_done2     = (w_c1 == 2'd3);
    assign w_byte      = w_done1 ? w_s1 : w_s2;
    assign w_byte_done = w_done1 || w_done2;

    always_comb begin
        w_state_nxt = r_state;
        if (w_samp) begin
            case (r_state)
                S_IDLE:  if (rm_crs_dv && !r_skip) w_state_nxt = S_ALIGN;
                S_ALIGN: if (w_eof)                w_state_nxt = S_IDLE;
                         else if (w_align)         w_state_nxt = S_RECV;
                S_RECV:  if (w_eof)                w_state_nxt = S_FLUSH;
                default:                           w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge rmii_clk or posedge w_rm_rst) begin
        if (w_rm_rst) begin
            r_state    <= S_IDLE;
            r_skip     <= 1'b1;
            r_low_prev <= 1'b0;
            r_div      <= 4'd0;
            r_dcnt     <= 2'd0;
            r_shift    <= 8'd0;
            r_pend     <= 1'b0;
            r_pend_d   <= 2'd0;
            r_cnt      <= 16'd0;
            r_hold     <= 8'd0;
            r_byte_tgl <= 1'b0;
            r_eof_tgl  <= 1'b0;
            r_active   <= 1'b0;
            r_len_hold <= 16'd0;
            r_err_hold <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // The alignment edge counts as phase 0 of the divide-by-10.
            if (w_align)              r_div <= 4'd1;
            else if (r_div == 4'd9)   r_div <= 4'd0;
            else                      r_div <= r_div + 4'd1;

            if (w_samp) begin
                r_low_prev <= ~rm_crs_dv;
                case (r_state)
                    S_IDLE: begin
                        if (w_eof) r_skip <= 1'b0;
                        r_cnt  <= 16'd0;
                        r_dcnt <= 2'd0;
                        r_pend <= 1'b0;
                    end
                    S_ALIGN: begin
                        if (w_align) begin
                            r_shift  <= {rm_rx_data, r_shift[7:2]};
                            r_dcnt   <= 2'd1;
                            r_active <= 1'b1;
                        end
                    end
                    S_RECV: begin
                        if (w_eof) begin
                            // The parked low dibit was the first end marker.
                            r_active   <= 1'b0;
                            r_eof_tgl  <= ~r_eof_tgl;
                            r_len_hold <= r_cnt;
                            r_err_hold <= (r_dcnt != 2'd0);
                            r_pend     <= 1'b0;
                        end else if (!rm_crs_dv) begin
                            r_pend   <= 1'b1;
                            r_pend_d <= rm_rx_data;
                        end else begin
                            r_shift <= w_s2;
                            r_dcnt  <= w_c1 + 2'd1;
                            r_pend  <= 1'b0;
                            if (w_byte_done) begin
                                r_hold     <= w_byte;
                                r_byte_tgl <= ~r_byte_tgl;
                                if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // clk domain: toggles and the active level cross through the same
    // synchronizer chain; holding registers are read on toggle edges.
    // ------------------------------------------------------------------
    logic [2:0]                    w_cross;
    logic [c_SYNC_DEPTH-1:0][2:0]  r_sync;
    logic [2:0]                    r_sync_q;
    logic [2:0]                    w_sync_last;
    logic                          w_byte_edge, w_eof_edge, w_act_rise;
    logic [7:0]                    r_data;
    logic                          r_rdy, r_busy, r_done, r_err;
    logic [15:0]                   r_len;

    assign w_cross     = {r_active, r_eof_tgl, r_byte_tgl};
    assign w_sync_last = r_sync[c_SYNC_DEPTH-1];
    assign w_byte_edge = w_sync_last[0] ^ r_sync_q[0];
    assign w_eof_edge  = w_sync_last[1] ^ r_sync_q[1];
    assign w_act_rise  = w_sync_last[2] & ~r_sync_q[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= '0;
            r_sync_q <= 3'd0;
            r_data   <= 8'd0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_len    <= 16'd0;
        end else begin
            r_sync   <= {r_sync[c_SYNC_DEPTH-2:0], w_cross};
            r_sync_q <= w_sync_last;
            r_rdy    <= w_byte_edge;
            r_done   <= w_eof_edge;
            r_err    <= w_eof_edge & r_err_hold;
            if (w_byte_edge) r_data <= r_hold;
            if (w_eof_edge)  r_len  <= r_len_hold;
            // busy drops on the same edge that raises done.
            if (w_eof_edge)      r_busy <= 1'b0;
            else if (w_act_rise) r_busy <= 1'b1;
        end
    end

    assign data      = r_data;
    assign rdy       = r_rdy;
    assign busy      = r_busy;
    assign done      = r_done;
    assign frame_len = r_len;
    assign err_align = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rmii_rx_dibit_asm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rmii_rx_dibit_asm
//  Purpose  : Directed self-checking bench for rmii_rx_dibit_asm.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rmii_rx_dibit_asm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rmii_clk = 1'b0;
    logic        fast_eth = 1'b1;
    logic [1:0]  rm_rx_data = 2'b00;
    logic        rm_crs_dv = 1'b0;
    logic [7:0]  data;
    logic        rdy, busy, done, err_align;
    logic [15:0] frame_len;

    int          n_cmp = 0;
    int          n_mis = 0;

    logic [7:0]  rx_q[$];
    int          done_cnt = 0;
    logic [15:0] last_len = 16'd0;
    logic        last_err = 1'b0;
    int          bsy_viol = 0;
    int          busy_seen = 0;
    logic        prev_busy = 1'b0;

    always #5 clk = ~clk;
    initial begin
        #3;
        forever #10 rmii_clk = ~rmii_clk;
    end

    rmii_rx_dibit_asm #(.SYNC_STAGES(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rmii_clk   (rmii_clk),
        .fast_eth   (fast_eth),
        .rm_rx_data (rm_rx_data),
        .rm_crs_dv  (rm_crs_dv),
        .data       (data),
        .rdy        (rdy),
        .busy       (busy),
        .done       (done),
        .frame_len  (frame_len),
        .err_align  (err_align)
    );

    // Output monitor, sampled half a clk period after the active edge.
    always @(negedge clk) begin
        if (rdy) begin
            rx_q.push_back(data);
            if (!busy) bsy_viol++;
        end
        if (done) begin
            done_cnt++;
            last_len = frame_len;
            last_err = err_align;
            if (busy || !prev_busy) bsy_viol++;
        end
        if (busy) busy_seen++;
        prev_busy = busy;
    end

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        if (i < 7)        return 8'h55;
        else if (i == 7)  return 8'hD5;
        else if (i < 68)  return 8'(i - 7);
        else if (i == 68) return 8'hA6;
        else              return 8'h3F;
    endfunction

    task automatic send_dibit(input logic [1:0] d, input logic crs);
        int n;
        n = fast_eth ? 1 : 10;
        repeat (n) begin
            @(negedge rmii_clk);
            rm_rx_data = d;
            rm_crs_dv  = crs;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) send_dibit(b[2*k +: 2], 1'b1);
    endtask

    task automatic clear_mon();
        rx_q.delete();
        done_cnt  = 0;
        bsy_viol  = 0;
        busy_seen = 0;
    endtask

    task automatic send_gap(input int n);
        for (int i = 0; i < n; i++) send_dibit(2'b00, 1'b0);
    endtask

    task automatic send_head();
        send_gap(8);
        for (int i = 0; i < 4; i++) send_dibit(2'b00, 1'b1);
    endtask

    // tail: 0 = clean end, 1 = two extra dibits, 2 = last 8 dibits with CRS_DV toggling
    task automatic send_frame(input int tail);
        logic [7:0] b;
        send_head();
        for (int i = 0; i < 68; i++) send_byte(exp_byte(i));
        if (tail == 1) begin
            send_dibit(2'b11, 1'b1);
            send_dibit(2'b10, 1'b1);
        end
        if (tail == 2) begin
            for (int i = 68; i < 70; i++) begin
                b = exp_byte(i);
                for (int k = 0; k < 4; k++) send_dibit(b[2*k +: 2], (k % 2) == 1);
            end
        end
        send_gap(6);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
    endtask

    task automatic check_frame(input string name, input int nbytes, input logic err);
        wait_done(500);
        check_val({name, "_rdy_count"}, rx_q.size(), nbytes);
        for (int i = 0; i < rx_q.size() && i < nbytes; i++)
            check_val($sformatf("%s_byte%0d", name, i), rx_q[i], exp_byte(i));
        check_val({name, "_done_count"}, done_cnt, 1);
        check_val({name, "_frame_len"}, last_len, nbytes);
        check_val({name, "_err_align"}, last_err, err);
        check_val({name, "_busy_order"}, bsy_viol, 0);
        check_val({name, "_busy_after"}, busy, 0);
    endtask

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        check_val("rst_data", data, 0);
        check_val("rst_rdy", rdy, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_frame_len", frame_len, 0);
        check_val("rst_err_align", err_align, 0);
        rst = 1'b0;

        // 100 Mb/s clean frame
        clear_mon();
        send_frame(0);
        check_frame("fast", 68, 1'b0);

        // 10 Mb/s clean frame
        fast_eth = 1'b0;
        clear_mon();
        send_frame(0);
        check_frame("slow", 68, 1'b0);
        fast_eth = 1'b1;

        // Frame ending two dibits into a byte
        clear_mon();
        send_frame(1);
        check_frame("partial", 68, 1'b1);

        // CRS_DV toggling during FIFO drain
        clear_mon();
        send_frame(2);
        check_frame("toggle", 70, 1'b0);

        // Zero whole bytes with a partial byte
        clear_mon();
        send_head();
        send_dibit(2'b01, 1'b1);
        send_dibit(2'b01, 1'b1);
        send_gap(6);
        wait_done(500);
        check_val("zero_rdy_count", rx_q.size(), 0);
        check_val("zero_done_count", done_cnt, 1);
        check_val("zero_frame_len", last_len, 0);
        check_val("zero_err_align", last_err, 1);

        // CRS_DV with only 00 dibits: no frame at all
        clear_mon();
        send_gap(8);
        for (int i = 0; i < 6; i++) send_dibit(2'b00, 1'b1);
        send_gap(6);
        repeat (50) @(negedge clk);
        check_val("noalign_rdy_count", rx_q.size(), 0);
        check_val("noalign_done_count", done_cnt, 0);
        check_val("noalign_busy_seen", busy_seen, 0);

        // Reset in mid-frame, then remainder of that frame must be ignored
        clear_mon();
        send_head();
        for (int i = 0; i < 20; i++) send_byte(exp_byte(i));
        repeat (10) @(negedge clk);
        check_val("abort_rdy_before", rx_q.size(), 20);
        #3 rst = 1'b1;
        #40 rst = 1'b0;
        @(negedge clk);
        check_val("abort_busy", busy, 0);
        clear_mon();
        for (int i = 20; i < 68; i++) send_byte(exp_byte(i));
        send_gap(6);
        repeat (50) @(negedge clk);
        check_val("abort_rdy_after", rx_q.size(), 0);
        check_val("abort_done_count", done_cnt, 0);

        // Next frame decodes normally
        clear_mon();
        send_frame(0);
        check_frame("recover", 68, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
